// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// N-client arbiter and multiplexer in front of one single-port synchronous RAM
// (the S, K and decrypted-message memories of the RC4 datapath). Clients ask
// for ownership with req, receive a registered one-hot gnt, and may keep the
// grant across multi-cycle read-modify-write sequences with lock. Reads are
// tracked through a READ_LATENCY-deep tag pipeline so that returning data is
// steered to the client that issued it, even after the grant has moved on.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> rotating priority; the search starts one
//                                    past the last granted client.
//                       undefined -> fixed priority, lowest index wins; no
//                                    pointer register exists.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req          per-client access request (one access per cycle when granted)
//   lock         per-client hold: keep the grant while req is low
//   we           per-client write enable (1 = write, 0 = read)
//   addr, wdata  packed client address / write data, client i at [i*W +: W]
//   gnt          one-hot registered grant
//   rvalid       one-cycle read-return strobe per client
//   rdata        read data, broadcast to all clients, qualified by rvalid
//   busy         a grant is held or a read is still in flight
//   ram_address, ram_data, ram_wren   RAM command (zero outside access cycles)
//   ram_q        RAM read data, valid READ_LATENCY cycles after the address
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_CLIENTS  = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            lock,
  input  logic [NUM_CLIENTS-1:0]            we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic [NUM_CLIENTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy,
  output logic [ADDR_WIDTH-1:0]             ram_address,
  output logic [DATA_WIDTH-1:0]             ram_data,
  output logic                              ram_wren,
  input  logic [DATA_WIDTH-1:0]             ram_q
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic [NUM_CLIENTS-1:0]             gnt_q, gnt_d;
  logic [READ_LATENCY-1:0]            pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][IDX_W-1:0] pipe_idx_q, pipe_idx_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] gnt_idx;
  logic             access;
  logic             rd_access;

  // ---------------------------------------------------------------------------
  // Winner selection among the current requesters.
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr_q holds the index where the next search begins, i.e. one past the
  // last granted client; it starts at 0 so the first grant after reset
  // behaves like fixed priority.
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [NUM_CLIENTS-1:0]   req_rot;
  int                       rot_off;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    req_dbl   = {req, req};
    req_rot   = req_dbl[NUM_CLIENTS-1:0];
    rot_off   = 0;
    win_found = |req;
    // Rotating the doubled vector puts the search start at bit 0; the lowest
    // set bit of the rotated view is then the offset from the pointer.
    req_rot = NUM_CLIENTS'(req_dbl >> rr_ptr_q);
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = i;
    end
    win_idx = IDX_W'((int'(rr_ptr_q) + rot_off) % NUM_CLIENTS);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && win_found) begin
      rr_ptr_d = IDX_W'((int'(win_idx) + 1) % NUM_CLIENTS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win_idx   = '0;
    win_found = |req;
    // Scanning downwards leaves the lowest requesting index as the winner.
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Grant FSM: next state and next grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = NUM_CLIENTS'(1) << win_idx;
        end
      end
      GRANT: begin
        // The owner keeps the grant while it is either requesting or locked.
        if (!(|(gnt_q & req)) && !(|(gnt_q & lock))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM command mux. The grant is one-hot, so an AND-OR mux is enough.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    access      = 1'b0;
    gnt_idx     = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_q[i]) gnt_idx = IDX_W'(i);
      if (gnt_q[i] && req[i]) begin
        access      = 1'b1;
        ram_address = ram_address | addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data    = ram_data    | wdata[i*DATA_WIDTH +: DATA_WIDTH];
        ram_wren    = ram_wren    | we[i];
      end
    end
    rd_access = access & ~ram_wren;
  end

  // ---------------------------------------------------------------------------
  // Read-return tag pipeline. Stage 0 is loaded by the access cycle, so the
  // tag reaches the last stage exactly when the RAM presents the data.
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_vld_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = rd_access;
    pipe_idx_d[0] = gnt_idx;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its _d value from before the edge.
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. ram_q already comes from the RAM's registered output stage, so it
  // is forwarded in the cycle its tag leaves the pipeline rather than being
  // registered again (which would add a cycle beyond READ_LATENCY).
  // ---------------------------------------------------------------------------
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rvalid[i] = pipe_vld_q[READ_LATENCY-1] &&
                  (pipe_idx_q[READ_LATENCY-1] == IDX_W'(i));
    end
  end

  assign rdata = pipe_vld_q[READ_LATENCY-1] ? ram_q : '0;
  assign gnt   = gnt_q;
  assign busy  = (state_q == GRANT) || (|pipe_vld_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with three clients and a two-cycle RAM. A
// behavioural RAM sits on the RAM port; expected read data comes from the
// bench's own shadow copy of memory and is queued when a read is issued, then
// matched against rvalid/rdata whenever the DUT returns data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NC = 3;
  localparam int RL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    req, lock, we;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic [AW-1:0]    ram_address;
  logic [DW-1:0]    ram_data;
  logic             ram_wren;
  logic [DW-1:0]    ram_q;

  always #5 clk = ~clk;

  ram_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_CLIENTS (NC),
    .READ_LATENCY(RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .busy       (busy),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  // ---------------------------------------------------------------------------
  // Behavioural synchronous RAM with RL cycles of read latency. Unwritten
  // words return a fixed pattern so no initialisation process is needed.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h10) ? 8'h3C : (a ^ 8'h5A);
  endfunction

  logic [DW-1:0]   mem     [2**AW];
  logic [2**AW-1:0] written = '0;
  logic [DW-1:0]   q_pipe  [RL];

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address]     <= ram_data;
      written[ram_address] <= 1'b1;
    end
    q_pipe[0] <= written[ram_address] ? mem[ram_address] : init_val(ram_address);
    for (int k = 1; k < RL; k++) q_pipe[k] <= q_pipe[k-1];
  end

  assign ram_q = q_pipe[RL-1];

  // ---------------------------------------------------------------------------
  // Checking and scoreboard.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            client;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           sb[$];
  logic [DW-1:0] exp_mem [2**AW];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
  endtask

  task automatic push_rd(input int c, input logic [AW-1:0] a);
    rd_t e;
    e.client = c;
    e.data   = exp_mem[a];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        rd_t e;
        e = sb.pop_front();
        check("sb_rvalid", 32'(rvalid), 32'(1) << e.client);
        check("sb_rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge, outputs are
  // sampled on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_client(input int c, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c]            = r;
    we[c]             = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  int order [5] = '{0, 1, 2, 0, 1};
`else
  int order [5] = '{0, 0, 0, 0, 0};
`endif

  initial begin
    for (int a = 0; a < 2**AW; a++) exp_mem[a] = init_val(AW'(a));

    // Reset held with every client requesting a write.
    rst   = 1'b1;
    req   = '1;
    we    = '1;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) begin
      settle();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_wren", 32'(ram_wren), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    next_cycle();
    rst = 1'b0;
    req = '0;
    we  = '0;
    settle();
    check("idle_busy", 32'(busy), 32'h0);

    // Single write from client 1.
    next_cycle();
    set_client(1, 1'b1, 1'b1, 8'h05, 8'hA5);
    settle();
    check("wr_gnt_latency", 32'(gnt), 32'h0);
    check("wr_idle_wren", 32'(ram_wren), 32'h0);
    next_cycle();
    exp_mem[8'h05] = 8'hA5;
    settle();
    check("wr_gnt", 32'(gnt), 32'b010);
    check("wr_wren", 32'(ram_wren), 32'h1);
    check("wr_addr", 32'(ram_address), 32'h05);
    check("wr_data", 32'(ram_data), 32'hA5);
    check("wr_busy", 32'(busy), 32'h1);
    next_cycle();
    set_client(1, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("wr_hold_gnt", 32'(gnt), 32'b010);
    check("wr_noacc_wren", 32'(ram_wren), 32'h0);
    check("wr_noacc_addr", 32'(ram_address), 32'h0);
    check("wr_noacc_data", 32'(ram_data), 32'h0);
    next_cycle();
    settle();
    check("wr_rel_gnt", 32'(gnt), 32'h0);
    check("wr_rel_busy", 32'(busy), 32'h0);

    // Read by client 0; it drops req right after its access cycle.
    next_cycle();
    set_client(0, 1'b1, 1'b0, 8'h10, 8'h00);
    settle();
    check("rd_gnt_latency", 32'(gnt), 32'h0);
    next_cycle();
    push_rd(0, 8'h10);
    settle();
    check("rd_gnt", 32'(gnt), 32'b001);
    check("rd_addr", 32'(ram_address), 32'h10);
    check("rd_wren", 32'(ram_wren), 32'h0);
    next_cycle();
    set_client(0, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("rd_early_rvalid", 32'(rvalid), 32'h0);
    check("rd_hold_gnt", 32'(gnt), 32'b001);
    next_cycle();
    settle();
    check("rd_rvalid", 32'(rvalid), 32'b001);
    check("rd_rdata", 32'(rdata), 32'h3C);
    check("rd_gnt_cleared", 32'(gnt), 32'h0);
    check("rd_busy_inflight", 32'(busy), 32'h1);
    next_cycle();
    settle();
    check("rd_done_busy", 32'(busy), 32'h0);

    // Contention between clients 0 and 2 under fixed priority.
    next_cycle();
    set_client(0, 1'b1, 1'b1, 8'h30, 8'h11);
    set_client(2, 1'b1, 1'b1, 8'h20, 8'h77);
    settle();
    check("ct_gnt_latency", 32'(gnt), 32'h0);
    next_cycle();
    exp_mem[8'h30] = 8'h11;
    settle();
    check("ct_gnt0", 32'(gnt), 32'b001);
    check("ct_wr0_wren", 32'(ram_wren), 32'h1);
    check("ct_wr0_addr", 32'(ram_address), 32'h30);
    check("ct_wr0_data", 32'(ram_data), 32'h11);
    next_cycle();
    set_client(0, 1'b1, 1'b0, 8'h30, 8'h00);
    push_rd(0, 8'h30);
    settle();
    check("ct_raw_addr", 32'(ram_address), 32'h30);
    check("ct_raw_wren", 32'(ram_wren), 32'h0);
    next_cycle();
    set_client(0, 1'b1, 1'b0, 8'h10, 8'h00);
    push_rd(0, 8'h10);
    settle();
    check("ct_rd2_gnt", 32'(gnt), 32'b001);
    next_cycle();
    set_client(0, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("ct_release_gnt", 32'(gnt), 32'b001);
    check("ct_b2b_rvalid_a", 32'(rvalid), 32'b001);
    next_cycle();
    settle();
    check("ct_idle_gnt", 32'(gnt), 32'h0);
    check("ct_b2b_rvalid_b", 32'(rvalid), 32'b001);
    next_cycle();
    exp_mem[8'h20] = 8'h77;
    settle();
    check("ct_gnt2", 32'(gnt), 32'b100);
    check("ct_wr2_wren", 32'(ram_wren), 32'h1);
    check("ct_wr2_addr", 32'(ram_address), 32'h20);
    check("ct_wr2_data", 32'(ram_data), 32'h77);
    next_cycle();
    set_client(2, 1'b1, 1'b0, 8'h20, 8'h00);
    push_rd(2, 8'h20);
    settle();
    check("ct_rd2_wren", 32'(ram_wren), 32'h0);
    next_cycle();
    set_client(2, 1'b0, 1'b0, 8'h00, 8'h00);
    settle();
    check("ct_rel2_gnt", 32'(gnt), 32'b100);
    next_cycle();
    settle();
    check("ct_rel2_idle", 32'(gnt), 32'h0);
    check("ct_rd2_rvalid", 32'(rvalid), 32'b100);
    next_cycle();
    settle();
    check("ct_done_busy", 32'(busy), 32'h0);

    // Lock: client 1 keeps the grant with req low while client 0 waits.
    next_cycle();
    set_client(1, 1'b1, 1'b1, 8'h40, 8'h99);
    lock[1] = 1'b1;
    settle();
    check("lk_gnt_latency", 32'(gnt), 32'h0);
    next_cycle();
    exp_mem[8'h40] = 8'h99;
    settle();
    check("lk_gnt", 32'(gnt), 32'b010);
    check("lk_wr_wren", 32'(ram_wren), 32'h1);
    next_cycle();
    set_client(1, 1'b0, 1'b0, 8'h00, 8'h00);
    set_client(0, 1'b1, 1'b0, 8'h40, 8'h00);
    repeat (3) begin
      settle();
      check("lk_hold_gnt", 32'(gnt), 32'b010);
      check("lk_hold_wren", 32'(ram_wren), 32'h0);
      next_cycle();
    end
    lock[1] = 1'b0;
    settle();
    check("lk_unlock_gnt", 32'(gnt), 32'b010);
    next_cycle();
    settle();
    check("lk_idle_gnt", 32'(gnt), 32'h0);
    next_cycle();
    push_rd(0, 8'h40);
    settle();
    check("lk_next_gnt", 32'(gnt), 32'b001);
    check("lk_next_addr", 32'(ram_address), 32'h40);
    next_cycle();
    set_client(0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();
    settle();
    check("lk_rd_rvalid", 32'(rvalid), 32'b001);
    next_cycle();
    settle();
    check("lk_done_busy", 32'(busy), 32'h0);

    // Grant order with all clients re-requesting after every single access.
    // Reset first so the round-robin pointer starts from zero.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) set_client(c, 1'b1, 1'b0, 8'h50 + 8'(c), 8'h00);
    for (int r = 0; r < 5; r++) begin
      next_cycle();
      push_rd(order[r], 8'h50 + 8'(order[r]));
      settle();
      check("order_gnt", 32'(gnt), 32'(1) << order[r]);
      next_cycle();
      req[order[r]] = 1'b0;
      next_cycle();
      req[order[r]] = 1'b1;
    end
    next_cycle();
    req = '0;
    repeat (3) next_cycle();
    settle();
    check("order_done_busy", 32'(busy), 32'h0);

    // Reset while a read is in flight: its return must be discarded.
    next_cycle();
    set_client(0, 1'b1, 1'b0, 8'h10, 8'h00);
    next_cycle();
    settle();
    check("mr_gnt", 32'(gnt), 32'b001);
    next_cycle();
    rst = 1'b1;
    set_client(0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();
    rst = 1'b0;
    settle();
    check("mr_rvalid", 32'(rvalid), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_gnt_cleared", 32'(gnt), 32'h0);
    next_cycle();
    settle();
    check("mr_rvalid_late", 32'(rvalid), 32'h0);

    next_cycle();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
